fifo_rd_packer: RTL and testbench

//  Read-side consumer of the async FIFO; runs entirely in the reader (rclk) domain.

---
 rtl/fifo_pkg.sv | 35 +++
 rtl/fifo_out_reg.sv | 92 +++++++++
 rtl/fifo_rd_packer.sv | 181 ++++++++++++++++++
 tb/tb_fifo_rd_packer.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_pkg                                                      |
// | Purpose  : Shared definitions for the async FIFO and its read-side       |
// |            packer: packer state encoding, default widths and the log2    |
// |            helper used to size counters.                                 |
// | Ports    : none (package)                                                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fifo_pkg;

  localparam int c_DEF_DATA_WIDTH = 8;
  localparam int c_DEF_PACK_RATIO = 4;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    FULL  = 2'd1,
    FLUSH = 2'd2
  } pack_state_e;

  // Ceiling log2; returns 0 for values <= 1.
  function automatic int fifo_log2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_out_reg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_out_reg                                                  |
// | Purpose  : Valid/ready output holding register for the read packer.      |
// |            Captures data/bytes/last (and lane parity when enabled) on    |
// |            load and holds them stable until the word is accepted.        |
// | Macro    : FIFO_PACK_PARITY_EN adds per-lane even parity (par_o).        |
// | Ports    : rclk, reset        - clock, synchronous active-high reset     |
// |            load_i             - load a new word (only when out_free_o)   |
// |            data_i/bytes_i/last_i - word to load                          |
// |            out_ready_i        - downstream accept                        |
// |            out_free_o         - register empty or being drained          |
// |            valid_o/data_o/bytes_o/last_o[/par_o] - held output word      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_out_reg
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int  PACK_RATIO = c_DEF_PACK_RATIO,
  localparam int CNT_W      = fifo_log2(PACK_RATIO + 1),
  localparam int ACC_W      = DATA_WIDTH * PACK_RATIO
) (
  input  logic             rclk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [ACC_W-1:0] data_i,
  input  logic [CNT_W-1:0] bytes_i,
  input  logic             last_i,
  input  logic             out_ready_i,
  output logic             out_free_o,
`ifdef FIFO_PACK_PARITY_EN
  output logic [PACK_RATIO-1:0] par_o,
`endif
  output logic             valid_o,
  output logic [ACC_W-1:0] data_o,
  output logic [CNT_W-1:0] bytes_o,
  output logic             last_o
);

  logic             valid_q;
  logic [ACC_W-1:0] data_q;
  logic [CNT_W-1:0] bytes_q;
  logic             last_q;

  assign out_free_o = !valid_q || out_ready_i;

`ifdef FIFO_PACK_PARITY_EN
  logic [PACK_RATIO-1:0] par_d;
  logic [PACK_RATIO-1:0] par_q;

  // Zeroed (unfilled) lanes reduce to parity 0 automatically.
  for (genvar g = 0; g < PACK_RATIO; g++) begin : g_par
    assign par_d[g] = ^data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge rclk) begin
    if (reset) begin
      par_q <= '0;
    end else if (load_i) begin
      par_q <= par_d;
    end
  end

  assign par_o = par_q;
`endif

  always_ff @(posedge rclk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      bytes_q <= '0;
      last_q  <= 1'b0;
    end else begin
      if (load_i) begin
        valid_q <= 1'b1;
        data_q  <= data_i;
        bytes_q <= bytes_i;
        last_q  <= last_i;
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign bytes_o = bytes_q;
  assign last_o  = last_q;

endmodule : fifo_out_reg
`default_nettype wire

// File: rtl/fifo_rd_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fifo_rd_packer                                                |
// | Purpose  : Read-side consumer of the async FIFO (rclk domain). Drains    |
// |            DATA_WIDTH words via get/empty_bar/fifo_data, packs           |
// |            PACK_RATIO of them little-endian into one wide word and       |
// |            presents it on a valid/ready stream. A flush pulse emits the  |
// |            partial word with its lane count and out_last=1.              |
// | Macro    : FIFO_PACK_PARITY_EN adds out_par (per-lane even parity).      |
// | Ports    : rclk, reset   - clock, synchronous active-high reset          |
// |            empty_bar     - FIFO holds data                               |
// |            get           - FIFO read strobe (combinational)              |
// |            fifo_data     - FIFO read data, valid when get && empty_bar   |
// |            flush         - emit the partial word                         |
// |            out_valid/out_ready - output handshake                        |
// |            out_data/out_bytes/out_last[/out_par] - output word           |
// |            busy          - partial data, held word or pending flush      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int  DATA_WIDTH = c_DEF_DATA_WIDTH,
  parameter int  PACK_RATIO = c_DEF_PACK_RATIO,
  localparam int CNT_W      = fifo_log2(PACK_RATIO + 1),
  localparam int ACC_W      = DATA_WIDTH * PACK_RATIO
) (
  input  logic                  rclk,
  input  logic                  reset,
  input  logic                  empty_bar,
  output logic                  get,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_W-1:0]      out_data,
  output logic [CNT_W-1:0]      out_bytes,
  output logic                  out_last,
`ifdef FIFO_PACK_PARITY_EN
  output logic [PACK_RATIO-1:0] out_par,
`endif
  output logic                  busy
);

  pack_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             flush_pend_q, flush_pend_d;

  logic             get_c;
  logic             flush_clr;
  logic             out_free;
  logic             load;
  logic [ACC_W-1:0] load_data;
  logic [CNT_W-1:0] load_bytes;
  logic             load_last;
  logic [CNT_W-1:0] wr_lane;
  logic [ACC_W-1:0] acc_masked;

  // Lanes at or above cnt may hold stale data from an earlier word.
  always_comb begin
    acc_masked = '0;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (CNT_W'(i) < cnt_q) begin
        acc_masked[i*DATA_WIDTH +: DATA_WIDTH] = acc_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    get_c      = 1'b0;
    flush_clr  = 1'b0;
    load       = 1'b0;
    load_data  = acc_q;
    load_bytes = CNT_W'(PACK_RATIO);
    load_last  = 1'b0;
    wr_lane    = cnt_q;

    case (state_q)
      FILL: begin
        get_c = empty_bar && !flush_pend_q && (cnt_q < CNT_W'(PACK_RATIO));
        if (get_c) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (cnt_d == CNT_W'(PACK_RATIO)) begin
          state_d = FULL;
        end else if (flush_pend_q) begin
          state_d = FLUSH;
        end
      end

      FULL: begin
        if (out_free) begin
          load       = 1'b1;
          load_data  = acc_q;
          load_bytes = CNT_W'(PACK_RATIO);
          load_last  = 1'b0;
          // Refill lane 0 in the hand-off cycle to keep one word per clock;
          // a pending flush blocks it so the flushed word stays empty or short.
          get_c      = empty_bar && !flush_pend_q;
          wr_lane    = '0;
          cnt_d      = get_c ? CNT_W'(1) : '0;
          state_d    = flush_pend_q ? FLUSH : FILL;
        end
      end

      FLUSH: begin
        if (cnt_q == '0) begin
          flush_clr = 1'b1;
          state_d   = FILL;
        end else if (out_free) begin
          load       = 1'b1;
          load_data  = acc_masked;
          load_bytes = cnt_q;
          load_last  = 1'b1;
          cnt_d      = '0;
          flush_clr  = 1'b1;
          state_d    = FILL;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    if (get_c) begin
      for (int i = 0; i < PACK_RATIO; i++) begin
        if (wr_lane == CNT_W'(i)) begin
          acc_d[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
        end
      end
    end
  end

  // A flush arriving in the same cycle the previous one is served stays pending.
  assign flush_pend_d = flush || (flush_pend_q && !flush_clr);

  always_ff @(posedge rclk) begin
    if (reset) begin
      state_q      <= FILL;
      cnt_q        <= '0;
      acc_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  assign get  = get_c && !reset;
  assign busy = (cnt_q != '0) || out_valid || flush_pend_q;

  fifo_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .PACK_RATIO (PACK_RATIO)
  ) u_out_reg (
    .rclk        (rclk),
    .reset       (reset),
    .load_i      (load),
    .data_i      (load_data),
    .bytes_i     (load_bytes),
    .last_i      (load_last),
    .out_ready_i (out_ready),
    .out_free_o  (out_free),
`ifdef FIFO_PACK_PARITY_EN
    .par_o       (out_par),
`endif
    .valid_o     (out_valid),
    .data_o      (out_data),
    .bytes_o     (out_bytes),
    .last_o      (out_last)
  );

endmodule : fifo_rd_packer
`default_nettype wire

// File: tb/tb_fifo_rd_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fifo_rd_packer                                             |
// | Purpose  : Self-checking bench for fifo_rd_packer. A byte-stream model   |
// |            (queue of captured bytes, split into groups of PACK_RATIO or  |
// |            cut short by flush markers) predicts every output word.       |
// | Macro    : FIFO_PACK_PARITY_EN also checks out_par.                      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PR = 4;
  localparam int W  = DW * PR;
  localparam int CW = 3;

  logic          rclk = 1'b0;
  logic          reset;
  logic          empty_bar;
  logic          get;
  logic [DW-1:0] fifo_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_bytes;
  logic          out_last;
  logic          busy;
`ifdef FIFO_PACK_PARITY_EN
  logic [PR-1:0] out_par;
`endif

  fifo_rd_packer #(
    .DATA_WIDTH (DW),
    .PACK_RATIO (PR)
  ) dut (
    .rclk      (rclk),
    .reset     (reset),
    .empty_bar (empty_bar),
    .get       (get),
    .fifo_data (fifo_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_bytes (out_bytes),
    .out_last  (out_last),
`ifdef FIFO_PACK_PARITY_EN
    .out_par   (out_par),
`endif
    .busy      (busy)
  );

  always #5 rclk = ~rclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [W-1:0] data;
    int           bytes;
    logic         last;
  } word_t;

  byte unsigned src_q[$];   // bytes the emulated FIFO still holds
  byte unsigned cur_q[$];   // bytes captured into the word being built
  word_t        exp_q[$];   // words the DUT still owes downstream

  function automatic void model_emit(input logic last);
    word_t w;
    w.data = '0;
    for (int i = 0; i < cur_q.size(); i++) w.data[i*DW +: DW] = cur_q[i];
    w.bytes = cur_q.size();
    w.last  = last;
    exp_q.push_back(w);
    cur_q.delete();
  endfunction

  // ---------------- stimulus knobs / observations ----------------
  int           p_avail   = 100;
  int           p_ready   = 100;
  bit           flush_req = 1'b0;
  bit           rst_req   = 1'b0;

  int           get_cnt    = 0;
  int           words_seen = 0;
  int           run_get    = 0;
  int           max_run    = 0;
  logic [W-1:0] last_data;
  int           last_bytes;
  logic         last_last;
  logic [PR-1:0] last_par;
  bit           stall_prev = 1'b0;
  logic [W-1:0] prev_data;
  logic [CW-1:0] prev_bytes;
  logic         prev_last;

  task automatic monitor();
    word_t        w;
    byte unsigned b;
    logic [PR-1:0] ep;
    check_eq("get_gating", (get && !empty_bar) || (get && reset), 1'b0);
    if (!reset) begin
      if (stall_prev) begin
        check_eq("hold_valid", out_valid, 1'b1);
        check_eq("hold_data",  out_data,  prev_data);
        check_eq("hold_bytes", out_bytes, prev_bytes);
        check_eq("hold_last",  out_last,  prev_last);
      end
      if (out_valid && out_ready) begin
        words_seen++;
        last_data  = out_data;
        last_bytes = int'(out_bytes);
        last_last  = out_last;
`ifdef FIFO_PACK_PARITY_EN
        last_par   = out_par;
`endif
        check_eq("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          w = exp_q.pop_front();
          check_eq("word_data",  out_data,  w.data);
          check_eq("word_bytes", out_bytes, w.bytes);
          check_eq("word_last",  out_last,  w.last);
          for (int i = 0; i < PR; i++) ep[i] = ^w.data[i*DW +: DW];
`ifdef FIFO_PACK_PARITY_EN
          check_eq("word_par", out_par, ep);
`endif
        end
      end
      if (get && empty_bar) begin
        get_cnt++;
        run_get++;
        if (run_get > max_run) max_run = run_get;
        b = src_q.pop_front();
        cur_q.push_back(b);
        if (cur_q.size() == PR) model_emit(1'b0);
      end else begin
        run_get = 0;
      end
      if (flush && cur_q.size() != 0) model_emit(1'b1);
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_bytes = out_bytes;
      prev_last  = out_last;
    end else begin
      cur_q.delete();
      exp_q.delete();
      stall_prev = 1'b0;
      run_get    = 0;
    end
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
    reset     = rst_req;
    flush     = flush_req;
    flush_req = 1'b0;
    out_ready = ($urandom_range(99) < p_ready);
    empty_bar = (src_q.size() > 0) && ($urandom_range(99) < p_avail);
    fifo_data = empty_bar ? src_q[0] : DW'($urandom);
    @(negedge rclk);
    monitor();
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((src_q.size() != 0 || exp_q.size() != 0 || out_valid) && n < 400) begin
      step();
      n++;
    end
    step();
    step();
    check_eq(tag, (src_q.size() == 0) && (exp_q.size() == 0), 1'b1);
  endtask

  task automatic push4(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) src_q.push_back(t[i*8 +: 8]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_get, base_words, n;
    reset     = 1'b1;
    flush     = 1'b0;
    empty_bar = 1'b0;
    out_ready = 1'b1;
    fifo_data = '0;

    // 1. reset held 3 cycles with data available
    rst_req = 1'b1;
    push4(32'h44332211);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("rst_get",   get,       1'b0);
      check_eq("rst_valid", out_valid, 1'b0);
      check_eq("rst_busy",  busy,      1'b0);
    end
    rst_req = 1'b0;

    // 2. one full word
    base_words = words_seen;
    drain("t2_drain");
    check_eq("t2_count", words_seen - base_words, 1);
    check_eq("t2_data",  last_data,  32'h44332211);
    check_eq("t2_bytes", last_bytes, 4);
    check_eq("t2_last",  last_last,  1'b0);

    // 3. partial word via flush, then flush with nothing pending
    src_q.push_back(8'h11);
    src_q.push_back(8'h22);
    drain("t3_fill");
    flush_req = 1'b1;
    step();
    drain("t3_drain");
    check_eq("t3_data",  last_data,  32'h00002211);
    check_eq("t3_bytes", last_bytes, 2);
    check_eq("t3_last",  last_last,  1'b1);
    base_words = words_seen;
    flush_req  = 1'b1;
    repeat (6) step();
    check_eq("t3_empty_flush", words_seen - base_words, 0);
    check_eq("t3_idle", busy, 1'b0);

    // 4. backpressure: one word held, exactly one more word gathered
    p_ready  = 0;
    base_get = get_cnt;
    base_words = words_seen;
    push4(32'h44332211);
    push4(32'h88776655);
    repeat (20) step();
    check_eq("t4_gets",  get_cnt - base_get, 8);
    check_eq("t4_get0",  get,       1'b0);
    check_eq("t4_valid", out_valid, 1'b1);
    check_eq("t4_held",  out_data,  32'h44332211);
    p_ready = 100;
    drain("t4_drain");
    check_eq("t4_count", words_seen - base_words, 2);
    check_eq("t4_data2", last_data, 32'h88776655);

    // 5. streaming 16 bytes at full rate
    run_get    = 0;
    max_run    = 0;
    base_words = words_seen;
    for (int i = 0; i < 16; i++) src_q.push_back(8'($urandom));
    drain("t5_drain");
    check_eq("t5_run",   max_run, 16);
    check_eq("t5_count", words_seen - base_words, 4);

    // 6. reset after two captures discards the partial word
    base_get = get_cnt;
    src_q.push_back(8'hA1);
    src_q.push_back(8'hA2);
    n = 0;
    while (get_cnt - base_get < 2 && n < 20) begin
      step();
      n++;
    end
    check_eq("t6_captures", get_cnt - base_get, 2);
    rst_req = 1'b1;
    step();
    step();
    rst_req = 1'b0;
    step();
    check_eq("t6_rst_valid", out_valid, 1'b0);
    check_eq("t6_rst_busy",  busy,      1'b0);
    push4(32'h7E8001FF);
    drain("t6_drain");
    check_eq("t6_data",  last_data,  32'h7E8001FF);
    check_eq("t6_bytes", last_bytes, 4);
`ifdef FIFO_PACK_PARITY_EN
    check_eq("t6_par", last_par, 4'b0110);
`endif

    // 7. randomized traffic, gaps, backpressure and flushes
    p_avail = 70;
    p_ready = 60;
    for (int i = 0; i < 800; i++) begin
      if (src_q.size() < 6 && $urandom_range(99) < 50) begin
        n = $urandom_range(1, 5);
        for (int k = 0; k < n; k++) src_q.push_back(8'($urandom));
      end
      flush_req = ($urandom_range(99) < 3);
      step();
    end
    p_avail   = 100;
    p_ready   = 100;
    drain("t7_drain_data");
    flush_req = 1'b1;
    step();
    drain("t7_drain");
    check_eq("t7_model_empty", cur_q.size(), 0);
    check_eq("t7_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_rd_packer
`default_nettype wire
